mfp_mac_seq_ctrl: RTL and testbench

//  Sequencer for the time-multiplexed fixed-point MAC (MFP_MAC_Seq). Accepts one ArrL-sample

---
 rtl/mfp_mac_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_mfp_mac_seq_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_mac_seq_ctrl.sv
// Sequencer for the time-multiplexed MAC: serialises one vector a tap per cycle,
// clears the accumulator on tap 0, waits out pipeline latency and returns the result.
module mfp_mac_seq_ctrl #(
    parameter int In1W     = 8,
    parameter int ArrL     = 16,
    parameter int AccW     = 15,
    parameter int COEF_LAT = 0,
    parameter int MAC_LAT  = 0,
    localparam int CoefAW  = (ArrL > 1) ? $clog2(ArrL) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [In1W*ArrL-1:0]   in_data,
    output logic [CoefAW-1:0]      coef_addr,
    output logic [In1W-1:0]        mac_in1,
    output logic                   mac_aclr,
    input  logic [AccW-1:0]        mac_acc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AccW-1:0]        out_data,
    output logic                   busy
);

    localparam int D   = COEF_LAT + MAC_LAT + 1;
    localparam int DrW = $clog2(D + 1);
    localparam logic [CoefAW-1:0] LastTap   = CoefAW'(ArrL - 1);
    localparam logic [DrW-1:0]    LastDrain = DrW'(D - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CoefAW-1:0]      tap_cnt;
    logic [DrW-1:0]         drain_cnt;
    logic [In1W*ArrL-1:0]   vec_reg;
    logic [In1W-1:0]        smp_p0;
    logic                   aclr_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            drain_cnt <= '0;
            vec_reg   <= '0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                vec_reg <= in_data;
            end
            if (state == RUN) begin
                tap_cnt <= (tap_cnt == LastTap) ? '0 : tap_cnt + CoefAW'(1);
            end
            if (state == DRAIN) begin
                drain_cnt <= (drain_cnt == LastDrain) ? '0 : drain_cnt + DrW'(1);
                // Accumulator has absorbed the last tap by the final drain cycle
                if (drain_cnt == LastDrain) begin
                    out_data <= mac_acc;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)                state_nxt = RUN;
            RUN:     if (tap_cnt == LastTap)      state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == LastDrain)  state_nxt = DONE;
            DONE:    if (out_ready)               state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        coef_addr = '0;
        aclr_p0   = 1'b0;
        smp_p0    = '0;
        if (state == RUN) begin
            coef_addr = tap_cnt;
            aclr_p0   = (tap_cnt == '0);
            for (int k = 0; k < ArrL; k++) begin
                if (tap_cnt == CoefAW'(k)) begin
                    smp_p0 = vec_reg[In1W*k +: In1W];
                end
            end
        end
    end

    // ---- align sample/aclr with coefficient read latency ----
    generate
        if (COEF_LAT == 0) begin : g_no_align
            assign mac_in1  = smp_p0;
            assign mac_aclr = aclr_p0;
        end else begin : g_align
            logic [In1W-1:0]     smp_pipe  [COEF_LAT];
            logic [COEF_LAT-1:0] aclr_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < COEF_LAT; i++) begin
                        smp_pipe[i]  <= '0;
                        aclr_pipe[i] <= 1'b0;
                    end
                end else begin
                    smp_pipe[0]  <= smp_p0;
                    aclr_pipe[0] <= aclr_p0;
                    for (int i = 1; i < COEF_LAT; i++) begin
                        smp_pipe[i]  <= smp_pipe[i-1];
                        aclr_pipe[i] <= aclr_pipe[i-1];
                    end
                end
            end

            assign mac_in1  = smp_pipe[COEF_LAT-1];
            assign mac_aclr = aclr_pipe[COEF_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_mfp_mac_seq_ctrl.sv
// Bench for mfp_mac_seq_ctrl: four sequencer instances, each driving a small MAC
// model with a coefficient ROM; results checked against a dot-product scoreboard.
module tb_mfp_mac_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [3:0]       iv, ir, ov, bz, acl, ordy;
    logic [127:0]     idat [4];
    logic [3:0][3:0]  ca;
    logic [3:0][7:0]  mi;
    logic [3:0][14:0] od, macc;

    logic signed [7:0]  rom [4][16];
    logic signed [31:0] acc [4];
    logic signed [31:0] acc1_d;
    logic signed [7:0]  cb_d1, cb_d2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int aclr_cnt0 = 0;
    logic [14:0] exp_last;
    logic [14:0] exp_q [$];

    always #5 clk = ~clk;

    assign ca[2][3:2] = 2'b00;
    assign ca[3][3:1] = 3'b000;

    mfp_mac_seq_ctrl u_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .coef_addr(ca[0]), .mac_in1(mi[0]), .mac_aclr(acl[0]), .mac_acc(macc[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0]));

    mfp_mac_seq_ctrl #(.COEF_LAT(2), .MAC_LAT(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .coef_addr(ca[1]), .mac_in1(mi[1]), .mac_aclr(acl[1]), .mac_acc(macc[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1]));

    mfp_mac_seq_ctrl #(.ArrL(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2][31:0]),
        .coef_addr(ca[2][1:0]), .mac_in1(mi[2]), .mac_aclr(acl[2]), .mac_acc(macc[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bz[2]));

    mfp_mac_seq_ctrl #(.ArrL(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(idat[3][7:0]),
        .coef_addr(ca[3][0]), .mac_in1(mi[3]), .mac_aclr(acl[3]), .mac_acc(macc[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .busy(bz[3]));

    // MAC model: instance 1 has a 2-cycle coefficient store and one output register
    function automatic logic signed [31:0] prod(input int i);
        logic signed [31:0] a;
        logic signed [31:0] b;
        a = 32'($signed(mi[i]));
        b = (i == 1) ? 32'(cb_d2) : 32'(rom[i][ca[i]]);
        return a * b;
    endfunction

    always @(posedge clk) begin
        cb_d1  <= rom[1][ca[1]];
        cb_d2  <= cb_d1;
        acc1_d <= acc[1];
        for (int i = 0; i < 4; i++) begin
            acc[i] <= acl[i] ? prod(i) : acc[i] + prod(i);
        end
        cyc <= cyc + 1;
        if (acl[0]) aclr_cnt0 <= aclr_cnt0 + 1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) macc[i] = acc[i][14:0];
        macc[1] = acc1_d[14:0];
    end

    function automatic logic [14:0] dot(input int id, input logic [127:0] v, input int n);
        logic signed [31:0] s;
        logic signed [7:0]  x;
        s = 0;
        for (int k = 0; k < n; k++) begin
            x = v[8*k +: 8];
            s = s + 32'(x) * 32'(rom[id][k]);
        end
        return s[14:0];
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1 (cycle 0 = handshake)
    task automatic send(input int id, input logic [127:0] vec, input int n);
        int w;
        w = 0;
        idat[id] = vec;
        iv[id] = 1'b1;
        while (!ir[id] && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!ir[id]) begin
            errors++;
            $display("FAIL send%0d_ready: in_ready=%b required 1", id, ir[id]);
        end
        exp_q.push_back(dot(id, vec, n));
        t0 = cyc;
        @(negedge clk);
        iv[id] = 1'b0;
        idat[id] = ~vec;
    endtask

    task automatic collect(input int id, input int exp_cyc, input string nm);
        int w;
        w = 0;
        while (!ov[id] && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!ov[id]) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", nm, w);
        end else begin
            checks++;
            if (cyc - t0 != exp_cyc) begin
                errors++;
                $display("FAIL %s_latency: result at cycle %0d, required %0d", nm, cyc - t0, exp_cyc);
            end
            exp_last = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h0;
            checks++;
            if (od[id] !== exp_last) begin
                errors++;
                $display("FAIL %s_data: out_data=%0h required %0h", nm, od[id], exp_last);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv = 4'h0;
        ordy = 4'hF;
        for (int i = 0; i < 4; i++) idat[i] = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ir !== 4'h0) begin
                errors++;
                $display("FAIL reset_in_ready: in_ready=%b required 0000", ir);
            end
            checks++;
            if (ov !== 4'h0 || bz !== 4'h0) begin
                errors++;
                $display("FAIL reset_state: out_valid=%b busy=%b required 0000", ov, bz);
            end
        end
        checks++;
        if (od !== '0) begin
            errors++;
            $display("FAIL reset_out_data: out_data=%0h required 0", od);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ir !== 4'hF) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1111", ir);
        end
    endtask

    task automatic test_basic();
        logic [127:0] vec;
        vec = '0;
        for (int k = 0; k < 16; k++) begin
            rom[0][k] = 8'sd1;
            vec[8*k +: 8] = 8'(k + 1);
        end
        ordy[0] = 1'b0;
        send(0, vec, 16);
        collect(0, 18, "basic");
        checks++;
        if (od[0] !== 15'd136) begin
            errors++;
            $display("FAIL basic_sum: out_data=%0d required 136", od[0]);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== exp_last) begin
                errors++;
                $display("FAIL basic_hold: out_valid=%b out_data=%0h required 1/%0h", ov[0], od[0], exp_last);
            end
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b required 0/1", ov[0], ir[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] v1, v2;
        int accepted, got, a0, t_acc0, t_acc1;
        for (int k = 0; k < 16; k++) begin
            rom[0][k] = 8'(k - 8);
            v1[8*k +: 8] = 8'($urandom);
            v2[8*k +: 8] = 8'($urandom);
        end
        accepted = 0; got = 0; t_acc0 = 0; t_acc1 = 0;
        a0 = aclr_cnt0;
        ordy[0] = 1'b1;
        idat[0] = v1;
        iv[0] = 1'b1;
        for (int w = 0; w < 200 && got < 2; w++) begin
            if (ov[0]) begin
                exp_last = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h0;
                checks++;
                if (od[0] !== exp_last) begin
                    errors++;
                    $display("FAIL b2b_data%0d: out_data=%0h required %0h", got, od[0], exp_last);
                end
                got++;
            end
            if (iv[0] && ir[0]) begin
                checks++;
                if (bz[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_accept_busy: busy=%b required 0", bz[0]);
                end
                exp_q.push_back(dot(0, (accepted == 0) ? v1 : v2, 16));
                if (accepted == 0) t_acc0 = cyc; else t_acc1 = cyc;
                accepted++;
            end
            @(negedge clk);
            if (accepted >= 1) idat[0] = v2;
            if (accepted >= 2) iv[0] = 1'b0;
        end
        iv[0] = 1'b0;
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL b2b_count: results=%0d required 2", got);
        end
        checks++;
        if (t_acc1 - t_acc0 != 19) begin
            errors++;
            $display("FAIL b2b_spacing: accept gap=%0d required 19", t_acc1 - t_acc0);
        end
        checks++;
        if (aclr_cnt0 - a0 != 2) begin
            errors++;
            $display("FAIL b2b_aclr: aclr pulses=%0d required 2", aclr_cnt0 - a0);
        end
    endtask

    task automatic test_latency();
        logic [127:0] vec;
        int aclr_at, w;
        vec = '0;
        for (int k = 0; k < 16; k++) begin
            rom[1][k] = 8'(k);
            vec[8*k +: 8] = 8'd2;
        end
        send(1, vec, 16);
        checks++;
        if (ca[1] !== 4'd0) begin
            errors++;
            $display("FAIL lat_addr0: coef_addr=%0d required 0", ca[1]);
        end
        aclr_at = -1;
        w = 0;
        while (!ov[1] && w < 200) begin
            if (acl[1] && aclr_at < 0) aclr_at = cyc - t0;
            @(negedge clk);
            w++;
        end
        collect(1, 21, "latency");
        checks++;
        if (od[1] !== 15'd240) begin
            errors++;
            $display("FAIL lat_sum: out_data=%0d required 240", od[1]);
        end
        checks++;
        if (aclr_at != 3) begin
            errors++;
            $display("FAIL lat_aclr: aclr at cycle %0d required 3", aclr_at);
        end
    endtask

    task automatic test_signed();
        for (int k = 0; k < 4; k++) rom[2][k] = 8'sd3;
        send(2, 128'hFFFF_FFFF, 4);
        collect(2, 6, "signed");
        checks++;
        if (od[2] !== 15'h7FF4) begin
            errors++;
            $display("FAIL signed_value: out_data=%0h required 7ff4", od[2]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] vec;
        for (int k = 0; k < 16; k++) begin
            rom[0][k] = 8'sd1;
            vec[8*k +: 8] = 8'($urandom);
        end
        send(0, vec, 16);
        repeat (7) @(negedge clk);
        checks++;
        if (ca[0] !== 4'd7) begin
            errors++;
            $display("FAIL abort_tap: coef_addr=%0d required 7", ca[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bz[0] !== 1'b0 || ov[0] !== 1'b0 || acl[0] !== 1'b0 || mi[0] !== 8'h0 || ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b out_valid=%b aclr=%b mac_in1=%0h in_ready=%b required 0/0/0/0/0",
                     bz[0], ov[0], acl[0], mi[0], ir[0]);
        end
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: in_ready=%b required 1", ir[0]);
        end
        for (int k = 0; k < 16; k++) vec[8*k +: 8] = 8'(16 - k);
        send(0, vec, 16);
        collect(0, 18, "after_abort");
    endtask

    task automatic test_single_tap();
        rom[3][0] = 8'sd7;
        send(3, 128'hFB, 1);
        checks++;
        if (acl[3] !== 1'b1 || ca[3] !== 4'd0) begin
            errors++;
            $display("FAIL single_tap0: aclr=%b coef_addr=%0d required 1/0", acl[3], ca[3]);
        end
        collect(3, 3, "single");
        checks++;
        if (od[3] !== 15'h7FDD) begin
            errors++;
            $display("FAIL single_value: out_data=%0h required 7fdd", od[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 16; k++) rom[i][k] = 8'sd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_latency();
        test_signed();
        test_reset_mid_run();
        test_single_tap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
